// File: rtl/jt49_pkg.sv
// Shared definitions for the JT49 PSG: register map, field positions and volume table.
package jt49_pkg;

   localparam int NumRegs = 16;

   localparam logic [3:0] RegToneAL   = 4'd0;
   localparam logic [3:0] RegToneAH   = 4'd1;
   localparam logic [3:0] RegToneBL   = 4'd2;
   localparam logic [3:0] RegToneBH   = 4'd3;
   localparam logic [3:0] RegToneCL   = 4'd4;
   localparam logic [3:0] RegToneCH   = 4'd5;
   localparam logic [3:0] RegNoise    = 4'd6;
   localparam logic [3:0] RegMixer    = 4'd7;
   localparam logic [3:0] RegAmpA     = 4'd8;
   localparam logic [3:0] RegAmpB     = 4'd9;
   localparam logic [3:0] RegAmpC     = 4'd10;
   localparam logic [3:0] RegEnvLo    = 4'd11;
   localparam logic [3:0] RegEnvHi    = 4'd12;
   localparam logic [3:0] RegEnvShape = 4'd13;
   localparam logic [3:0] RegIoA      = 4'd14;
   localparam logic [3:0] RegIoB      = 4'd15;

   localparam int unsigned ShapeCont = 3;
   localparam int unsigned ShapeAtt  = 2;
   localparam int unsigned ShapeAlt  = 1;
   localparam int unsigned ShapeHold = 0;
   localparam int unsigned MixIoA    = 6;
   localparam int unsigned MixIoB    = 7;
   localparam int unsigned AmpEnvBit = 4;

   // 1.5 dB per step, entry 31 first
   localparam logic [31:0][7:0] VolTable = {
      8'd255, 8'd215, 8'd181, 8'd152, 8'd128, 8'd108, 8'd90, 8'd76,
      8'd64,  8'd54,  8'd45,  8'd38,  8'd32,  8'd27,  8'd23, 8'd19,
      8'd16,  8'd14,  8'd11,  8'd10,  8'd8,   8'd7,   8'd6,  8'd5,
      8'd4,   8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd1,  8'd0
   };

   function automatic logic [7:0] reg_mask(input logic [3:0] idx);
      case (idx)
         RegToneAH, RegToneBH, RegToneCH, RegEnvShape: return 8'h0F;
         RegNoise, RegAmpA, RegAmpB, RegAmpC:          return 8'h1F;
         default:                                      return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] chan_vol(input logic gate, input logic [4:0] amp,
                                           input logic [4:0] env_lvl);
      logic [4:0] idx;
      if (amp[AmpEnvBit])        idx = env_lvl;
      else if (amp[3:0] == 4'd0) idx = 5'd0;
      else                       idx = {amp[3:0], 1'b1};
      return gate ? VolTable[idx] : 8'd0;
   endfunction

endpackage

// File: rtl/jt49_tone_ch.sv
// One square-wave tone channel: 12-bit period counter that toggles the output on wrap.
module jt49_tone_ch
   import jt49_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_i,
   input  logic [11:0] period_i,
   output logic        tone_o
);

   logic [11:0] cnt_q, cnt_d, cnt_inc, per_eff;
   logic        tone_q, tone_d;

   always_comb begin
      per_eff = (period_i == 12'd0) ? 12'd1 : period_i;
      cnt_inc = cnt_q + 12'd1;
      cnt_d   = cnt_q;
      tone_d  = tone_q;
      if (step_i) begin
         // >= so a shortened period takes effect without a full wrap
         if (cnt_inc >= per_eff) begin
            cnt_d  = 12'd0;
            tone_d = ~tone_q;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 12'd0;
         tone_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
      end
   end

   assign tone_o = tone_q;

endmodule

// File: rtl/jt49.sv
// JT49 programmable sound generator: register file, tone/noise/envelope generators, mixer.
module jt49
   import jt49_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic [3:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       wr_n,
   input  logic       cs_n,
   input  logic       sel,
   output logic [7:0] A,
   output logic [7:0] B,
   output logic [7:0] C,
   output logic [9:0] sound,
   output logic       sample,
   input  logic [7:0] IOA_in,
   input  logic [7:0] IOB_in,
   output logic [7:0] IOA_out,
   output logic [7:0] IOB_out
);

   logic [7:0]  regs_q [NumRegs];
   logic [7:0]  regs_d [NumRegs];
   logic        wr_en, tick, tone_step, noise_step;
   logic        div_q, div_d;
   logic [3:0]  pre_q, pre_d;
   logic [4:0]  noise_cnt_q, noise_cnt_d, noise_per;
   logic [16:0] lfsr_q, lfsr_d;
   logic [15:0] env_cnt_q, env_cnt_d, env_per, env_inc;
   logic [4:0]  env_step_q, env_step_d, env_lvl;
   logic        env_hold_q, env_hold_d, env_inv_q, env_inv_d;
   logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
   logic [9:0]  sound_q, sound_d;
   logic        sample_q;
   logic [2:0]  tone;
   logic [7:0]  mix;
   logic [3:0]  shape;

   assign wr_en      = ~cs_n & ~wr_n;
   assign tick       = clk_en & (sel | div_q);
   assign tone_step  = tick & (pre_q[2:0] == 3'd7);
   assign noise_step = tick & (pre_q == 4'hF);
   assign mix        = regs_q[RegMixer];
   assign shape      = regs_q[RegEnvShape][3:0];

   jt49_tone_ch u_tone_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (tone_step),
      .period_i({regs_q[RegToneAH][3:0], regs_q[RegToneAL]}),
      .tone_o  (tone[0])
   );

   jt49_tone_ch u_tone_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (tone_step),
      .period_i({regs_q[RegToneBH][3:0], regs_q[RegToneBL]}),
      .tone_o  (tone[1])
   );

   jt49_tone_ch u_tone_c (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (tone_step),
      .period_i({regs_q[RegToneCH][3:0], regs_q[RegToneCL]}),
      .tone_o  (tone[2])
   );

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[addr] = din & reg_mask(addr);
   end

   always_comb begin
      div_d       = clk_en ? ~div_q : div_q;
      pre_d       = tick ? pre_q + 4'd1 : pre_q;
      noise_per   = (regs_q[RegNoise][4:0] == 5'd0) ? 5'd1 : regs_q[RegNoise][4:0];
      noise_cnt_d = noise_cnt_q;
      lfsr_d      = lfsr_q;
      if (noise_step) begin
         if (noise_cnt_q + 5'd1 >= noise_per) begin
            noise_cnt_d = 5'd0;
            lfsr_d      = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
         end else begin
            noise_cnt_d = noise_cnt_q + 5'd1;
         end
      end
   end

   // Level direction is ATT flipped by env_inv_q; end-of-cycle actions only touch inv/hold/step
   always_comb begin
      env_lvl    = (shape[ShapeAtt] ^ env_inv_q) ? env_step_q : ~env_step_q;
      env_per    = {regs_q[RegEnvHi], regs_q[RegEnvLo]};
      env_per    = (env_per == 16'd0) ? 16'd1 : env_per;
      env_inc    = env_cnt_q + 16'd1;
      env_cnt_d  = env_cnt_q;
      env_step_d = env_step_q;
      env_hold_d = env_hold_q;
      env_inv_d  = env_inv_q;
      if (tone_step && !env_hold_q) begin
         if (env_inc >= env_per) begin
            env_cnt_d = 16'd0;
            if (env_step_q != 5'd31) begin
               env_step_d = env_step_q + 5'd1;
            end else if (!shape[ShapeCont]) begin
               env_hold_d = 1'b1;
               env_inv_d  = shape[ShapeAtt];
            end else if (shape[ShapeHold]) begin
               env_hold_d = 1'b1;
               env_inv_d  = env_inv_q ^ shape[ShapeAlt];
            end else if (shape[ShapeAlt]) begin
               env_inv_d  = ~env_inv_q;
               env_step_d = 5'd0;
            end else begin
               env_step_d = 5'd0;
            end
         end else begin
            env_cnt_d = env_inc;
         end
      end
      if (wr_en && addr == RegEnvShape) begin
         env_cnt_d  = 16'd0;
         env_step_d = 5'd0;
         env_hold_d = 1'b0;
         env_inv_d  = 1'b0;
      end
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sound_d = sound_q;
      if (tick) begin
         a_d = chan_vol((tone[0] | mix[0]) & (lfsr_q[0] | mix[3]), regs_q[RegAmpA][4:0], env_lvl);
         b_d = chan_vol((tone[1] | mix[1]) & (lfsr_q[0] | mix[4]), regs_q[RegAmpB][4:0], env_lvl);
         c_d = chan_vol((tone[2] | mix[2]) & (lfsr_q[0] | mix[5]), regs_q[RegAmpC][4:0], env_lvl);
         sound_d = {2'b00, a_d} + {2'b00, b_d} + {2'b00, c_d};
      end
   end

   always_comb begin
      dout = regs_q[addr];
      if (addr == RegIoA && !mix[MixIoA]) dout = IOA_in;
      if (addr == RegIoB && !mix[MixIoB]) dout = IOB_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) regs_q[i] <= 8'd0;
         div_q       <= 1'b0;
         pre_q       <= 4'd0;
         noise_cnt_q <= 5'd0;
         lfsr_q      <= 17'd1;
         env_cnt_q   <= 16'd0;
         env_step_q  <= 5'd0;
         env_hold_q  <= 1'b0;
         env_inv_q   <= 1'b0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         c_q         <= 8'd0;
         sound_q     <= 10'd0;
         sample_q    <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         div_q       <= div_d;
         pre_q       <= pre_d;
         noise_cnt_q <= noise_cnt_d;
         lfsr_q      <= lfsr_d;
         env_cnt_q   <= env_cnt_d;
         env_step_q  <= env_step_d;
         env_hold_q  <= env_hold_d;
         env_inv_q   <= env_inv_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         sound_q     <= sound_d;
         sample_q    <= tick;
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign C       = c_q;
   assign sound   = sound_q;
   assign sample  = sample_q;
   assign IOA_out = regs_q[RegIoA];
   assign IOB_out = regs_q[RegIoB];

endmodule

// File: tb/tb_jt49.sv
// Randomized bench for jt49 against a behavioural PSG model, plus directed scenarios.
module tb_jt49;

   logic       clk = 1'b0;
   logic       rst_n, clk_en, sel, wr_n, cs_n, sample;
   logic [3:0] addr;
   logic [7:0] din, dout, a, b, c, ioa_in, iob_in, ioa_out, iob_out;
   logic [9:0] sound;

   always #5 clk = ~clk;

   jt49 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .addr   (addr),
      .din    (din),
      .dout   (dout),
      .wr_n   (wr_n),
      .cs_n   (cs_n),
      .sel    (sel),
      .A      (a),
      .B      (b),
      .C      (c),
      .sound  (sound),
      .sample (sample),
      .IOA_in (ioa_in),
      .IOB_in (iob_in),
      .IOA_out(ioa_out),
      .IOB_out(iob_out)
   );

   int unsigned n_checks = 0, n_pass = 0;
   int  vol_ref[32];
   int  reg_width[16] = '{8, 4, 8, 4, 8, 4, 5, 8, 5, 5, 5, 8, 8, 4, 8, 8};
   int  m_reg[16];
   int  m_ce, m_nt, m_nc, m_lfsr, m_ec, m_es, m_sound;
   int  m_ph[3], m_out[3];
   bit  m_tone[3];
   bit  m_sample, ce_rand;
   int  cyc = 0, a_last = 0, a_iv = 0;
   logic [7:0] a_prev = 8'd0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic int env_level();
      int sh;
      bit att, alt, dir;
      sh  = m_reg[13];
      att = sh[2];
      alt = sh[1];
      if (m_es < 32) return att ? m_es : 31 - m_es;
      if (!sh[3]) return 0;
      if (sh[0]) return (att ^ alt) ? 31 : 0;
      dir = att ^ (alt && ((m_es / 32) % 2 == 1));
      return dir ? (m_es % 32) : 31 - (m_es % 32);
   endfunction

   function automatic int chan_ref(input int ch);
      int amp, idx, mix;
      bit gate;
      mix  = m_reg[7];
      gate = (m_tone[ch] | mix[ch]) & (m_lfsr[0] | mix[ch + 3]);
      amp  = m_reg[8 + ch];
      if (amp[4]) idx = env_level();
      else if ((amp & 15) == 0) idx = 0;
      else idx = 2 * (amp & 15) + 1;
      return gate ? vol_ref[idx] : 0;
   endfunction

   function automatic int dout_ref(input int ad);
      int mix;
      mix = m_reg[7];
      if (ad == 14 && !mix[6]) return int'(ioa_in);
      if (ad == 15 && !mix[7]) return int'(iob_in);
      return m_reg[ad];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 0;
      for (int i = 0; i < 3; i++) begin
         m_ph[i] = 0; m_tone[i] = 0; m_out[i] = 0;
      end
      m_ce = 0; m_nt = 0; m_nc = 0; m_lfsr = 1; m_ec = 0; m_es = 0;
      m_sound = 0; m_sample = 0;
   endtask

   // One rising clk edge of the reference PSG, using the inputs presented to it
   task automatic model_edge();
      bit tick;
      int tp, np, ep, fb;
      if (clk_en) m_ce++;
      tick = clk_en && (sel || (m_ce % 2 == 0));
      m_sample = tick;
      if (tick) begin
         for (int ch = 0; ch < 3; ch++) m_out[ch] = chan_ref(ch);
         m_sound = m_out[0] + m_out[1] + m_out[2];
         m_nt++;
         if (m_nt % 8 == 0) begin
            for (int ch = 0; ch < 3; ch++) begin
               tp = m_reg[2 * ch] + 256 * m_reg[2 * ch + 1];
               if (tp == 0) tp = 1;
               m_ph[ch]++;
               if (m_ph[ch] >= tp) begin
                  m_ph[ch] = 0;
                  m_tone[ch] = !m_tone[ch];
               end
            end
            ep = m_reg[11] + 256 * m_reg[12];
            if (ep == 0) ep = 1;
            if (!(m_es >= 32 && (!m_reg[13][3] || m_reg[13][0]))) begin
               m_ec++;
               if (m_ec >= ep) begin
                  m_ec = 0;
                  m_es++;
               end
            end
         end
         if (m_nt % 16 == 0) begin
            np = m_reg[6];
            if (np == 0) np = 1;
            m_nc++;
            if (m_nc >= np) begin
               m_nc = 0;
               fb = (m_lfsr ^ (m_lfsr >> 3)) & 1;
               m_lfsr = (m_lfsr >> 1) | (fb << 16);
            end
         end
      end
      if (!cs_n && !wr_n) begin
         m_reg[addr] = int'(din) & ((1 << reg_width[addr]) - 1);
         if (addr == 4'd13) begin
            m_ec = 0;
            m_es = 0;
         end
      end
   endtask

   task automatic cycle();
      clk_en = ce_rand ? 1'($urandom % 2) : 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      if (a !== a_prev) begin
         a_iv = cyc - a_last;
         a_last = cyc;
      end
      a_prev = a;
      check_eq("A", a, m_out[0]);
      check_eq("B", b, m_out[1]);
      check_eq("C", c, m_out[2]);
      check_eq("sound", sound, m_sound);
      check_eq("sample", sample, m_sample);
      check_eq("dout", dout, dout_ref(int'(addr)));
      check_eq("IOA_out", ioa_out, m_reg[14]);
      check_eq("IOB_out", iob_out, m_reg[15]);
   endtask

   task automatic wr(input int ad, input int d);
      cs_n = 1'b0;
      wr_n = 1'b0;
      addr = ad[3:0];
      din  = d[7:0];
      cycle();
      cs_n = 1'b1;
      wr_n = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Asynchronous assert between edges, checks during reset, release after two edges
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      cs_n  = 1'b1;
      wr_n  = 1'b1;
      #1;
      model_reset();
      check_eq("rst_A", a, 0);
      check_eq("rst_B", b, 0);
      check_eq("rst_C", c, 0);
      check_eq("rst_sound", sound, 0);
      check_eq("rst_sample", sample, 0);
      check_eq("rst_IOA_out", ioa_out, 0);
      check_eq("rst_IOB_out", iob_out, 0);
      addr = 4'($urandom_range(0, 13));
      #1;
      check_eq("rst_dout", dout, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      a_prev = 8'd0;
      a_last = cyc;
      a_iv   = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++)
         vol_ref[i] = (i == 0) ? 0 : $rtoi(255.0 * (10.0 ** (-(31 - i) * 1.5 / 20.0)) + 0.5);
      rst_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1; clk_en = 1'b0; sel = 1'b1;
      addr = 4'd0; din = 8'd0; ioa_in = 8'd0; iob_in = 8'd0; ce_rand = 0;
      #1 rst_n = 1'b0;
      #2;
      model_reset();
      for (int r = 0; r < 16; r++) begin
         addr = 4'(r);
         #1 check_eq("reset_read", dout, 0);
      end
      check_eq("reset_sound", sound, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Tone A, period 2, full scale, sel=1
      wr(0, 2); wr(1, 0); wr(7, 8'h3E); wr(8, 8'h0F);
      run(200);
      check_eq("tone_iv_sel1", a_iv, 16);

      // All channels fixed at full scale
      wr(9, 8'h0F); wr(10, 8'h0F); wr(7, 8'h3F);
      run(4);
      check_eq("full_A", a, 255);
      check_eq("full_sound", sound, 765);

      // sel=0 halves the base tick rate
      sel = 1'b0;
      do_reset();
      wr(0, 2); wr(1, 0); wr(7, 8'h3E); wr(8, 8'h0F);
      run(300);
      check_eq("tone_iv_sel0", a_iv, 32);

      // Envelope attack then hold
      sel = 1'b1;
      do_reset();
      wr(11, 1); wr(12, 0); wr(8, 8'h10); wr(7, 8'h3F); wr(13, 8'h0D);
      run(20);
      check_eq("env_ramping", a < 8'd255, 1);
      run(280);
      check_eq("env_top", a, 255);
      run(60);
      check_eq("env_hold", a, 255);

      // IO port direction
      wr(7, 8'h40); wr(14, 8'hA5);
      addr = 4'd14; ioa_in = 8'h5A;
      #1 check_eq("io_out_read", dout, 8'hA5);
      wr(7, 8'h00);
      addr = 4'd14; ioa_in = 8'h3C;
      #1 check_eq("io_in_read", dout, 8'h3C);
      check_eq("io_out_pin", ioa_out, 8'hA5);

      // Randomized sessions
      for (int s = 0; s < 8; s++) begin
         sel = 1'($urandom % 2);
         ce_rand = ($urandom % 2) == 1;
         do_reset();
         for (int r = 0; r < 16; r++) begin
            if (r == 0 || r == 2 || r == 4) wr(r, $urandom_range(0, 12));
            else if (r == 1 || r == 3 || r == 5) wr(r, ($urandom % 4 == 0) ? 1 : 0);
            else if (r == 11) wr(r, $urandom_range(0, 3));
            else if (r == 12) wr(r, 0);
            else wr(r, $urandom % 256);
         end
         for (int i = 0; i < 700; i++) begin
            if ($urandom % 20 == 0) begin
               wr($urandom % 16, $urandom % 256);
            end else begin
               addr   = 4'($urandom % 16);
               ioa_in = 8'($urandom);
               iob_in = 8'($urandom);
               cycle();
            end
            if (i == 350 && s % 2 == 1) do_reset();
         end
      end
      ce_rand = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jt49.md
JT49 -- requirements
Module: jt49

Interface
REQ-001 Ports SHALL be: clk in 1, sole clock, all logic on rising edge.
REQ-002 rst_n in 1, asynchronous active-low reset.
REQ-003 clk_en in 1, clock-enable strobe defining the PSG master clock rate.
REQ-004 addr in 4, register index for writes/reads.
REQ-005 din in 8, write data; dout out 8, read data of register at addr.
REQ-006 wr_n in 1, active-low write strobe; cs_n in 1, active-low chip select.
REQ-007 sel in 1, clock divider select: 1 = base tick every clk_en, 0 = base tick every second clk_en.
REQ-008 A, B, C out 8 each, per-channel registered amplitude.
REQ-009 sound out 10, registered unsigned mix A+B+C.
REQ-010 sample out 1, one-clk pulse marking each output update.
REQ-011 IOA_in, IOB_in in 8; IOA_out, IOB_out out 8, general-purpose ports.

Function
REQ-012 Register file of 16 regs SHALL be written on any clk edge with cs_n=0 and wr_n=0, independent of clk_en; unused bits stored as 0.
REQ-013 Widths: R0/R2/R4 8b, R1/R3/R5 4b (12-bit tone periods A/B/C); R6 5b noise period; R7 8b mixer; R8-R10 5b amplitude; R11/R12 16-bit envelope period (LSB/MSB); R13 4b shape; R14/R15 8b IO.
REQ-014 dout SHALL combinationally return reg[addr] masked to its width; R14/R15 return IOx_in when R7 bit6/bit7 is 0 (input), stored value when 1.
REQ-015 IOA_out = R14, IOB_out = R15 at all times.
REQ-016 Base tick: clk_en qualified by sel per REQ-007; all counters advance only on base ticks.
REQ-017 Tone: per channel 12-bit counter advancing every 8 base ticks; on reaching period, counter clears and square output toggles; period 0 treated as 1; full square period = 16*TP base ticks.
REQ-018 Noise: 5-bit counter advancing every 16 base ticks; on reaching NP (0 treated as 1) a 17-bit LFSR shifts, feedback bit0 XOR bit3; noise_out = LFSR bit0.
REQ-019 Mixer: channel gate = (tone_out | R7[ch]) & (noise_out | R7[ch+3]); gate 0 forces channel output 0.
REQ-020 Amplitude: R8+ch bit4=1 selects 5-bit envelope level; else fixed level L (4b) mapped to index 0 if L=0, else {L,1}.
REQ-021 Volume table: 32 entries, index 0 -> 0, index i>0 -> round(255 * 10^(-(31-i)*1.5/20)); index 31 -> 255.
REQ-022 Envelope: 16-bit counter advancing every 8 base ticks; on reaching EP (0 treated as 1) 5-bit step advances; 32 steps per cycle.
REQ-023 Shape bits CONT=3, ATT=2, ALT=1, HOLD=0; ATT=1 ramps 0->31, ATT=0 ramps 31->0.
REQ-024 End of cycle: CONT=0 -> hold 0; CONT=1,HOLD=1 -> hold final level, inverted if ALT=1; CONT=1,ALT=1,HOLD=0 -> reverse direction; else restart ramp.
REQ-025 Any write to R13 SHALL restart envelope: step 0, counter 0, hold cleared.
REQ-026 A/B/C and sound SHALL update on each base tick; sample=1 exactly on those clk cycles, 0 otherwise.
REQ-027 Simultaneous write and tick: new register value takes effect from the next base tick.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all registers, counters, tone outputs, envelope state; LFSR set to 1.
REQ-029 During reset A=B=C=0, sound=0, sample=0, IOA_out=IOB_out=0, dout=reg-derived (0 for R0-R13).
REQ-030 Reset mid-operation discards all pending state; first tick after release restarts from zero counters.

Structure
REQ-031 Register indices, bit-field positions and the 32-entry volume table SHALL live in a shared package.
REQ-032 One sub-module jt49_tone_ch (12-bit counter + square toggle) instantiated three times; noise, envelope, mixer inline.

Verification
REQ-033 Reset, then read R0-R15 with IO inputs 0 -> all dout 0, sound=0.
REQ-034 sel=1, clk_en=1, R0=2, R1=0, R7=0x3E, R8=0x0F -> A toggles 0/255 every 16 clks, sound 0/255.
REQ-035 R8=0x0F,R9=0x0F,R10=0x0F, R7=0x3F -> A=B=C=255, sound=765.
REQ-036 R11=1, R12=0, R13=0x0D, R8=0x10, R7=0x3F -> A ramps 0->255 over 32 steps (8 base ticks each) then holds 255.
REQ-037 sel=0 with REQ-034 setup -> toggle interval doubles to 32 clks.
REQ-038 R7=0x40, R14=0xA5; then R7=0x00, IOA_in=0x3C -> dout(14) returns 0xA5 then 0x3C; IOA_out=0xA5.
